// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, the latched
// request record and the external SRAM geometry.
package sram_arb_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {IDLE, H0, G0, H1, G1, ACK} state_t;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } sram_req_t;

    // Writes skip halves with no byte enables; reads always run both halves.
    function automatic state_t first_state(input sram_req_t r);
        state_t s;
        if (!r.we || (r.sel[3:2] != 2'b00)) s = H0;
        else if (r.sel[1:0] != 2'b00)        s = H1;
        else                                 s = ACK;
        return s;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant; the port that did not win last time is
// preferred when both request.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt_vld_o    = en_i && (req_i != 2'b00);
        gnt_idx_o    = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
        last_grant_d = gnt_vld_o ? gnt_idx_o : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit async SRAM between two 32-bit requesters; each access is
// split into two sequenced half-word cycles driven entirely from flops.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    clock_50,
    input  logic                    reset_n,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [1:0][16:0]        addr_i,
    input  logic [1:0][3:0]         sel_i,
    input  logic [1:0][31:0]        wdata_i,
    output logic [1:0]              ack_o,
    output logic [1:0][31:0]        rdata_o,
    output logic [SRAM_AW-1:0]      sram_addr,
    inout  wire  [SRAM_DW-1:0]      sram_dq,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic                    sram_ub_n,
    output logic                    sram_lb_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    gnt_q, gnt_d;
    sram_req_t               req_q, req_d, in_req;
    logic                    ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                    ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic [SRAM_AW-1:0]      addr_q, addr_d;
    logic                    dq_oe_q, dq_oe_d;
    logic [SRAM_DW-1:0]      dq_out_q, dq_out_d, hi_q, hi_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0][31:0]        rdata_q, rdata_d;
    logic                    gnt_vld, gnt_idx, h_last;

    sram_rr_arbiter u_rr (
        .clk       (clock_50),
        .rst_n     (reset_n),
        .req_i     (req_i),
        .en_i      (state_q == IDLE),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        in_req.we    = we_i[gnt_idx];
        in_req.addr  = addr_i[gnt_idx];
        in_req.sel   = sel_i[gnt_idx];
        in_req.wdata = wdata_i[gnt_idx];
    end

    assign h_last = (cnt_q == LAST);

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            req_q    <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            addr_q   <= '0;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
            hi_q     <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            req_q    <= req_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            addr_q   <= addr_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
            hi_q     <= hi_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_vld) begin
                    gnt_d   = gnt_idx;
                    req_d   = in_req;
                    state_d = first_state(in_req);
                end
            end
            H0: begin
                if (h_last) begin
                    cnt_d   = '0;
                    state_d = req_q.we ? G0 : H1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            G0:  state_d = (req_q.sel[1:0] != 2'b00) ? H1 : ACK;
            H1: begin
                if (h_last) begin
                    cnt_d   = '0;
                    state_d = req_q.we ? G1 : ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            G1:      state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change cleanly on
    // the clock; G states keep addr/dq/ce but release we_n for data hold.
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = dq_out_q;
        addr_d   = addr_q;
        ack_d    = 2'b00;
        hi_d     = hi_q;
        rdata_d  = rdata_q;
        case (state_d)
            H0, G0: begin
                ce_n_d = 1'b0;
                addr_d = {req_d.addr, 1'b0};
                if (req_d.we) begin
                    we_n_d   = (state_d == G0);
                    ub_n_d   = ~req_d.sel[3];
                    lb_n_d   = ~req_d.sel[2];
                    dq_oe_d  = 1'b1;
                    dq_out_d = req_d.wdata[31:16];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
            H1, G1: begin
                ce_n_d = 1'b0;
                addr_d = {req_d.addr, 1'b1};
                if (req_d.we) begin
                    we_n_d   = (state_d == G1);
                    ub_n_d   = ~req_d.sel[1];
                    lb_n_d   = ~req_d.sel[0];
                    dq_oe_d  = 1'b1;
                    dq_out_d = req_d.wdata[15:0];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
            ACK:     ack_d[gnt_d] = 1'b1;
            default: ;
        endcase
        if (!req_q.we && h_last && (state_q == H0)) hi_d = sram_dq;
        if (!req_q.we && h_last && (state_q == H1)) rdata_d[gnt_q] = {hi_q, sram_dq};
    end

    assign sram_dq   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;
    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a behavioural 256Kx16 SRAM on the pins of
// the default instance, plus a WAIT_CYCLES=1 instance on a pattern SRAM.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic clock_50 = 1'b0;
    logic reset_n;
    always #10 clock_50 = ~clock_50;

    logic [1:0]         req_i, we_i, ack_o;
    logic [1:0][16:0]   addr_i;
    logic [1:0][3:0]    sel_i;
    logic [1:0][31:0]   wdata_i, rdata_o;
    logic [17:0]        sram_addr;
    wire  [15:0]        sram_dq;
    logic               ce_n, oe_n, we_n, ub_n, lb_n;

    logic [1:0]         req_b, we_b, ack_b;
    logic [1:0][16:0]   addr_b;
    logic [1:0][3:0]    sel_b;
    logic [1:0][31:0]   wdata_b, rdata_b;
    logic [17:0]        sram_addr_b;
    wire  [15:0]        sram_dq_b;
    logic               ce_n_b, oe_n_b, we_n_b, ub_n_b, lb_n_b;

    int checks = 0;
    int failures = 0;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .clock_50(clock_50), .reset_n(reset_n), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .sel_i(sel_i), .wdata_i(wdata_i), .ack_o(ack_o),
        .rdata_o(rdata_o), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n));

    sram_arbiter #(.WAIT_CYCLES(1)) dut_b (
        .clock_50(clock_50), .reset_n(reset_n), .req_i(req_b), .we_i(we_b),
        .addr_i(addr_b), .sel_i(sel_b), .wdata_i(wdata_b), .ack_o(ack_b),
        .rdata_o(rdata_b), .sram_addr(sram_addr_b), .sram_dq(sram_dq_b),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b),
        .sram_ub_n(ub_n_b), .sram_lb_n(lb_n_b));

    // SRAM model for the main instance
    logic [15:0] mem [0:262143];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clock_50) begin
        if (!ce_n && !we_n) begin
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
        end
    end

    // Pattern SRAM for the single-wait instance: data = 0x1000 | address
    assign sram_dq_b = (!ce_n_b && !oe_n_b && we_n_b) ? (16'h1000 | sram_addr_b[15:0]) : 16'bz;
    int oe_cnt_b = 0;
    always @(posedge clock_50) if (!oe_n_b) oe_cnt_b <= oe_cnt_b + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // oe and we must never be low together, and dq must never be driven while oe is low
    always @(negedge clock_50) begin
        if (reset_n) check("bus_overlap", {31'b0, (!oe_n && (!we_n || dut.dq_oe_q))}, 32'd0);
    end

    task automatic access(input int p, input logic we, input logic [16:0] a, input logic [3:0] s,
                          input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                          input string tag);
        int lat;
        logic got;
        @(negedge clock_50);
        req_i[p] = 1'b1; we_i[p] = we; addr_i[p] = a; sel_i[p] = s; wdata_i[p] = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clock_50); #1;
            lat++;
            if (ack_o[p]) got = 1'b1;
        end
        req_i[p] = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        if (!we) check({tag, "_rdata"}, rdata_o[p], exp_rd);
        @(posedge clock_50); #1;
        check({tag, "_ack_once"}, {30'b0, ack_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock_50);
        reset_n = 1'b0;
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[$];
        int cyc, cnt0, lat;
        logic activity, doubled;

        reset_n = 1'b0;
        req_i = '0; we_i = '0; addr_i = '0; sel_i = '0; wdata_i = '0;
        req_b = '0; we_b = '0; addr_b = '0; sel_b = '0; wdata_b = '0;

        // 1. reset state
        repeat (3) @(posedge clock_50);
        #1;
        check("rst_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        check("rst_ack", {30'b0, ack_o}, 32'd0);
        check("rst_dq_oe", {31'b0, dut.dq_oe_q}, 32'd0);
        check("rst_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_rdata", rdata_o[0] | rdata_o[1], 32'd0);
        @(negedge clock_50);
        reset_n = 1'b1;
        activity = 1'b0;
        repeat (6) begin
            @(posedge clock_50); #1;
            activity |= (!ce_n || ack_o != 2'b00);
        end
        check("idle_quiet", {31'b0, activity}, 32'd0);

        // 2. full write then read on port 0
        access(0, 1'b1, 17'h00010, 4'b1111, 32'hDEADBEEF, 7, 32'h0, "wr0");
        check("mem20", {16'b0, mem[18'h20]}, 32'h0000DEAD);
        check("mem21", {16'b0, mem[18'h21]}, 32'h0000BEEF);
        access(0, 1'b0, 17'h00010, 4'b0000, 32'h0, 5, 32'hDEADBEEF, "rd0");

        // 3. single-byte write on port 1, then sel=0000 write
        access(1, 1'b1, 17'h00010, 4'b0010, 32'h0000AB00, 4, 32'h0, "bw1");
        check("mem21_byte", {16'b0, mem[18'h21]}, 32'h0000ABEF);
        check("mem20_keep", {16'b0, mem[18'h20]}, 32'h0000DEAD);
        access(1, 1'b0, 17'h00010, 4'b0000, 32'h0, 5, 32'hDEADABEF, "rd1");
        access(0, 1'b1, 17'h00010, 4'b0000, 32'hFFFFFFFF, 1, 32'h0, "wnone");
        check("wnone_mem", {mem[18'h20], mem[18'h21]}, 32'hDEADABEF);

        // 4. contention after reset: 0 then 1, then both held -> 0,1,0,1
        do_reset();
        @(negedge clock_50);
        req_i = 2'b11; we_i = 2'b00; addr_i[0] = 17'h10; addr_i[1] = 17'h10;
        doubled = 1'b0;
        cyc = 0;
        while (order.size() < 2 && cyc < 60) begin
            @(posedge clock_50); #1;
            cyc++;
            if (ack_o == 2'b11) doubled = 1'b1;
            if (ack_o[0]) begin order.push_back(0); req_i[0] = 1'b0; end
            if (ack_o[1]) begin order.push_back(1); req_i[1] = 1'b0; end
        end
        check("cont_count", order.size(), 32'd2);
        check("cont_first", (order.size() > 0) ? order[0] : -1, 32'd0);
        check("cont_second", (order.size() > 1) ? order[1] : -1, 32'd1);
        check("cont_rdata1", rdata_o[1], 32'hDEADABEF);
        order.delete();
        @(negedge clock_50);
        req_i = 2'b11;
        cyc = 0;
        while (order.size() < 4 && cyc < 80) begin
            @(posedge clock_50); #1;
            cyc++;
            if (ack_o == 2'b11) doubled = 1'b1;
            if (ack_o[0]) order.push_back(0);
            if (ack_o[1]) order.push_back(1);
        end
        req_i = 2'b00;
        check("alt_count", order.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("alt_%0d", i), (order.size() > i) ? order[i] : -1, i % 2);
        activity = 1'b0;
        repeat (10) begin
            @(posedge clock_50); #1;
            activity |= (ack_o != 2'b00);
        end
        check("no_extra_ack", {30'b0, activity, doubled}, 32'd0);

        // 5. reset in the middle of H1 of a write
        @(negedge clock_50);
        req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 17'h00040; sel_i[0] = 4'hF;
        wdata_i[0] = 32'h12345678;
        repeat (4) @(posedge clock_50);
        #1;
        check("h1_we_low", {31'b0, we_n}, 32'd0);
        check("h1_addr", {14'b0, sram_addr}, 32'h81);
        reset_n = 1'b0;
        #1;
        check("mid_rst_strobes", {30'b0, we_n, ce_n}, 32'h3);
        check("mid_rst_dq", {31'b0, dut.dq_oe_q}, 32'd0);
        req_i[0] = 1'b0;
        activity = 1'b0;
        repeat (3) begin
            @(posedge clock_50); #1;
            activity |= (ack_o != 2'b00);
        end
        @(negedge clock_50);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock_50); #1;
            activity |= (ack_o != 2'b00);
        end
        check("mid_rst_no_ack", {31'b0, activity}, 32'd0);
        access(0, 1'b0, 17'h00010, 4'b0000, 32'h0, 5, 32'hDEADABEF, "rd_after_rst");

        // 6. WAIT_CYCLES=1 read
        @(negedge clock_50);
        cnt0 = oe_cnt_b;
        req_b[0] = 1'b1; we_b[0] = 1'b0; addr_b[0] = 17'h00005;
        lat = 0;
        while (!ack_b[0] && lat < 40) begin
            @(posedge clock_50); #1;
            lat++;
        end
        req_b[0] = 1'b0;
        check("w1_lat", lat, 32'd3);
        check("w1_rdata", rdata_b[0], 32'h100A100B);
        repeat (3) @(posedge clock_50);
        #1;
        check("w1_oe_cycles", oe_cnt_b - cnt0, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
